// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared constants and parameter checks for the CDC receive bank
package cdc_pkg;

    // Shallowest synchroniser chain that still gives a metastability settling stage
    localparam int CDC_MIN_STAGES = 2;

    // True when a requested synchroniser depth is deep enough to be trusted
    function automatic bit cdc_stages_ok(input int stages);
        return (stages >= CDC_MIN_STAGES);
    endfunction

endpackage

// File: rtl/cdc_sync_cell.sv
// rtl/cdc_sync_cell.sv - single-bit multi-flop synchroniser chain
module cdc_sync_cell
    import cdc_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    if (!cdc_stages_ok(STAGES)) begin : g_bad_stages
        $error("cdc_sync_cell: STAGES must be at least CDC_MIN_STAGES");
    end

    // Flops in this chain are the synchroniser; no logic may sit between them
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the chain; first stage may go metastable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_rx_sync_bank.sv
// rtl/cdc_rx_sync_bank.sv - destination-side bank of level/pulse channels plus toggle-handshake data bus
module cdc_rx_sync_bank
    import cdc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter     PULSE_MASK  = 4'b0000,
    parameter int DATA_W      = 8
) (
    input  logic              clkB,
    input  logic              rstB,
    input  logic [NUM_CH-1:0] ch_in,
    output logic [NUM_CH-1:0] ch_out,
    input  logic              req_tgl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              ack_tgl_out
);

    if (!cdc_stages_ok(SYNC_STAGES)) begin : g_bad_stages
        $error("cdc_rx_sync_bank: SYNC_STAGES must be at least CDC_MIN_STAGES");
    end

    if ($bits(PULSE_MASK) != NUM_CH) begin : g_bad_mask
        $error("cdc_rx_sync_bank: PULSE_MASK width must equal NUM_CH");
    end

    localparam logic [NUM_CH-1:0] MODE_MASK = PULSE_MASK;

    // ------------------------------------------------------------------
    // 1-bit channels
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] ch_sync;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cdc_sync_cell #(
            .STAGES (SYNC_STAGES)
        ) u_ch_sync (
            .clk_i  (clkB),
            .rst_ni (rstB),
            .d_i    (ch_in[i]),
            .q_o    (ch_sync[i])
        );

        if (MODE_MASK[i]) begin : g_pulse
            logic prev_q;
            logic pulse_q;
            logic pulse_d;

            // Any change between the synced value and its last copy is one source transition
            always_comb begin
                pulse_d = ch_sync[i] ^ prev_q;
            end

            // Edge-history flop and registered one-cycle pulse output
            always_ff @(posedge clkB or negedge rstB) begin
                if (!rstB) begin
                    prev_q  <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    prev_q  <= ch_sync[i];
                    pulse_q <= pulse_d;
                end
            end

            assign ch_out[i] = pulse_q;
        end else begin : g_level
            assign ch_out[i] = ch_sync[i];
        end
    end

    // ------------------------------------------------------------------
    // Toggle-handshake data bus
    // ------------------------------------------------------------------
    logic              req_sync;
    logic              ack_q;
    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic              capture_d;

    cdc_sync_cell #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i  (clkB),
        .rst_ni (rstB),
        .d_i    (req_tgl_in),
        .q_o    (req_sync)
    );

    // A new word is pending whenever the synced request differs from the last acknowledged level
    always_comb begin
        capture_d = req_sync ^ ack_q;
    end

    // Capture data_in only on the qualifying edge; the ack register doubles as the toggle back to source
    always_ff @(posedge clkB or negedge rstB) begin
        if (!rstB) begin
            ack_q  <= 1'b0;
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q <= capture_d;
            if (capture_d) begin
                ack_q  <= req_sync;
                data_q <= data_in;
            end
        end
    end

    assign data_out    = data_q;
    assign data_vld    = vld_q;
    assign ack_tgl_out = ack_q;

endmodule

// File: tb/tb_cdc_rx_sync_bank.sv
// tb/tb_cdc_rx_sync_bank.sv - directed table plus handshake sequences for cdc_rx_sync_bank
module tb_cdc_rx_sync_bank;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int NVEC   = 18;
    localparam int NXFER  = 16;

    logic              clkB = 1'b0;
    logic              rstB = 1'b0;
    logic [NUM_CH-1:0] ch_in = '0;
    logic [NUM_CH-1:0] ch_out;
    logic              req_tgl_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              ack_tgl_out;

    cdc_rx_sync_bank #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (2),
        .PULSE_MASK  (4'b0010),
        .DATA_W      (DATA_W)
    ) dut (
        .clkB        (clkB),
        .rstB        (rstB),
        .ch_in       (ch_in),
        .ch_out      (ch_out),
        .req_tgl_in  (req_tgl_in),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_vld    (data_vld),
        .ack_tgl_out (ack_tgl_out)
    );

    always #15 clkB = ~clkB;

    int   half_a = 15;
    logic clk_a  = 1'b0;
    always #(half_a) clk_a = ~clk_a;

    logic ack_a1 = 1'b0;
    logic ack_a2 = 1'b0;
    always @(posedge clk_a) begin
        ack_a1 <= ack_tgl_out;
        ack_a2 <= ack_a1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] ch;
        logic       req;
        logic [7:0] din;
        logic [3:0] exp_ch;
        logic       exp_vld;
        logic       exp_ack;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs [0:NVEC-1];

    logic [DATA_W-1:0] exp_q[$];
    int                vld_cnt = 0;
    logic              mon_en  = 1'b0;

    // Scoreboard for back-to-back transfers: every data_vld must match the next word sent
    always @(negedge clkB) begin
        if (mon_en && data_vld) begin
            if (exp_q.size() == 0) begin
                check("b2b_unexpected_vld", vld_cnt, 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                check("b2b_data", vld_cnt, 32'(data_out), 32'(exp_q.pop_front()));
            end
            vld_cnt++;
        end
    end

    initial begin
        // ch, req, din | ch_out, vld, ack, dout after the following clkB edge
        vecs[0]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{4'b0001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{4'b0011, 1'b1, 8'hA5, 4'b0001, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{4'b0011, 1'b1, 8'hA5, 4'b0001, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{4'b0011, 1'b1, 8'hA5, 4'b0011, 1'b1, 1'b1, 8'hA5};
        vecs[5]  = '{4'b0001, 1'b1, 8'hA5, 4'b0001, 1'b0, 1'b1, 8'hA5};
        vecs[6]  = '{4'b0001, 1'b1, 8'h3C, 4'b0001, 1'b0, 1'b1, 8'hA5};
        vecs[7]  = '{4'b0000, 1'b0, 8'h3C, 4'b0011, 1'b0, 1'b1, 8'hA5};
        vecs[8]  = '{4'b0000, 1'b0, 8'h3C, 4'b0000, 1'b0, 1'b1, 8'hA5};
        vecs[9]  = '{4'b0000, 1'b0, 8'h3C, 4'b0000, 1'b1, 1'b0, 8'h3C};
        vecs[10] = '{4'b1111, 1'b1, 8'h5A, 4'b0000, 1'b0, 1'b0, 8'h3C};
        vecs[11] = '{4'b1111, 1'b1, 8'h5A, 4'b1101, 1'b0, 1'b0, 8'h3C};
        vecs[12] = '{4'b1111, 1'b1, 8'h5A, 4'b1111, 1'b1, 1'b1, 8'h5A};
        vecs[13] = '{4'b1111, 1'b1, 8'h5A, 4'b1101, 1'b0, 1'b1, 8'h5A};
        vecs[14] = '{4'b0000, 1'b1, 8'h5A, 4'b1101, 1'b0, 1'b1, 8'h5A};
        vecs[15] = '{4'b0000, 1'b1, 8'h5A, 4'b0000, 1'b0, 1'b1, 8'h5A};
        vecs[16] = '{4'b0000, 1'b1, 8'h5A, 4'b0010, 1'b0, 1'b1, 8'h5A};
        vecs[17] = '{4'b0000, 1'b1, 8'h5A, 4'b0000, 1'b0, 1'b1, 8'h5A};

        // Reset state
        repeat (3) @(negedge clkB);
        check("reset_ch_out", 0, 32'(ch_out), 32'h0);
        check("reset_data_vld", 0, 32'(data_vld), 32'h0);
        check("reset_ack", 0, 32'(ack_tgl_out), 32'h0);
        check("reset_data_out", 0, 32'(data_out), 32'h0);
        rstB = 1'b1;

        // Level, pulse, bus and simultaneous-event vectors
        for (int k = 0; k < NVEC; k++) begin
            ch_in      = vecs[k].ch;
            req_tgl_in = vecs[k].req;
            data_in    = vecs[k].din;
            @(negedge clkB);
            check("vec_ch_out", k, 32'(ch_out), 32'(vecs[k].exp_ch));
            check("vec_data_vld", k, 32'(data_vld), 32'(vecs[k].exp_vld));
            check("vec_ack", k, 32'(ack_tgl_out), 32'(vecs[k].exp_ack));
            check("vec_data_out", k, 32'(data_out), 32'(vecs[k].exp_dout));
        end

        // Asynchronous reset in the middle of a request toggle
        req_tgl_in = 1'b0;
        @(posedge clkB);
        #2 rstB = 1'b0;
        #1;
        check("midreset_data_out", 0, 32'(data_out), 32'h0);
        check("midreset_ack", 0, 32'(ack_tgl_out), 32'h0);
        check("midreset_data_vld", 0, 32'(data_vld), 32'h0);
        check("midreset_ch_out", 0, 32'(ch_out), 32'h0);
        repeat (2) @(negedge clkB);
        rstB = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clkB);
            check("postreset_data_vld", c, 32'(data_vld), 32'h0);
            check("postreset_ack", c, 32'(ack_tgl_out), 32'h0);
            check("postreset_data_out", c, 32'(data_out), 32'h0);
        end

        // Back-to-back handshakes from a source clock at a random ratio
        half_a = int'($urandom_range(5, 45));
        repeat (4) @(negedge clk_a);
        mon_en = 1'b1;
        for (int n = 0; n < NXFER; n++) begin
            int waited;
            waited = 0;
            while (ack_a2 !== req_tgl_in && waited < 400) begin
                @(negedge clk_a);
                waited++;
            end
            if (waited >= 400) begin
                check("b2b_ack_timeout", n, 32'(ack_a2), 32'(req_tgl_in));
                break;
            end
            @(negedge clk_a);
            data_in = DATA_W'($urandom);
            exp_q.push_back(data_in);
            req_tgl_in = ~req_tgl_in;
        end
        begin
            int waited;
            waited = 0;
            while (ack_a2 !== req_tgl_in && waited < 400) begin
                @(negedge clk_a);
                waited++;
            end
            check("b2b_final_ack", 0, 32'(ack_tgl_out), 32'(req_tgl_in));
        end
        repeat (4) @(negedge clkB);
        mon_en = 1'b0;
        check("b2b_vld_count", 0, 32'(vld_cnt), 32'(NXFER));
        check("b2b_queue_left", 0, 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
